// File: rtl/core_sequencer.sv
// Per-instruction control FSM between fetch and the decoder: sequences two-cycle
// jumps/branches, runs the LSU handshake with a timeout, and raises traps.
module core_sequencer #(
  parameter int LSU_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  logic       illegal_inst_i,
  input  logic       ecall_inst_i,
  input  logic       ebreak_inst_i,
  input  logic       mret_inst_i,
  input  logic       jump_inst_i,
  input  logic       branch_inst_i,
  input  logic       lsu_r_en_i,
  input  logic       lsu_w_en_i,
  input  logic       rf_we_i,
  input  logic       branch_taken_i,
  output logic       cycle_counter_o,
  output logic       rf_we_o,
  output logic       lsu_req_o,
  input  logic       lsu_gnt_i,
  input  logic       lsu_rvalid_i,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       trap_o,
  output logic [3:0] trap_cause_o
);

  localparam int CW = $clog2(LSU_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LSU_TIMEOUT - 1);

  localparam logic [1:0] SEL_INC  = 2'd0;
  localparam logic [1:0] SEL_ALU  = 2'd1;
  localparam logic [1:0] SEL_TRAP = 2'd2;
  localparam logic [1:0] SEL_MEPC = 2'd3;

  typedef enum logic [2:0] {
    DISPATCH,
    EXEC2,
    LSU_REQ,
    LSU_WAIT,
    TRAP
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cause, cause_nxt;
  logic            is_load, is_load_nxt;
  logic [CW-1:0]   cnt, cnt_inc;
  logic            in_lsu, tmo;

  assign in_lsu  = (state == LSU_REQ) || (state == LSU_WAIT);
  assign cnt_inc = cnt + 1'b1;
  // Fires on the last allowed LSU cycle; a same-cycle gnt/rvalid is checked first.
  assign tmo     = in_lsu && (cnt_inc >= TMO_LAST);

  always_comb begin
    state_nxt       = state;
    cause_nxt       = cause;
    is_load_nxt     = is_load;
    instr_ready_o   = 1'b0;
    cycle_counter_o = 1'b0;
    rf_we_o         = 1'b0;
    lsu_req_o       = 1'b0;
    pc_we_o         = 1'b0;
    pc_sel_o        = SEL_INC;
    trap_o          = 1'b0;
    trap_cause_o    = 4'd0;
    if (rst_n) begin
      case (state)
        DISPATCH: begin
          if (instr_valid_i) begin
            if (illegal_inst_i) begin
              state_nxt = TRAP;
              cause_nxt = 4'd2;
            end else if (ebreak_inst_i) begin
              state_nxt = TRAP;
              cause_nxt = 4'd3;
            end else if (ecall_inst_i) begin
              state_nxt = TRAP;
              cause_nxt = 4'd11;
            end else if (mret_inst_i) begin
              pc_we_o       = 1'b1;
              pc_sel_o      = SEL_MEPC;
              instr_ready_o = 1'b1;
            end else if (jump_inst_i) begin
              rf_we_o   = rf_we_i;
              state_nxt = EXEC2;
            end else if (branch_inst_i) begin
              if (branch_taken_i) begin
                state_nxt = EXEC2;
              end else begin
                pc_we_o       = 1'b1;
                instr_ready_o = 1'b1;
              end
            end else if (lsu_r_en_i || lsu_w_en_i) begin
              lsu_req_o   = 1'b1;
              is_load_nxt = lsu_r_en_i;
              if (!lsu_gnt_i) begin
                state_nxt = LSU_REQ;
              end else if (lsu_r_en_i) begin
                state_nxt = LSU_WAIT;
              end else begin
                pc_we_o       = 1'b1;
                instr_ready_o = 1'b1;
              end
            end else begin
              rf_we_o       = rf_we_i;
              pc_we_o       = 1'b1;
              instr_ready_o = 1'b1;
            end
          end
        end
        EXEC2: begin
          cycle_counter_o = 1'b1;
          pc_we_o         = 1'b1;
          pc_sel_o        = SEL_ALU;
          instr_ready_o   = 1'b1;
          state_nxt       = DISPATCH;
        end
        LSU_REQ: begin
          lsu_req_o = 1'b1;
          if (lsu_gnt_i) begin
            if (is_load) begin
              state_nxt = LSU_WAIT;
            end else begin
              pc_we_o       = 1'b1;
              instr_ready_o = 1'b1;
              state_nxt     = DISPATCH;
            end
          end else if (tmo) begin
            state_nxt = TRAP;
            cause_nxt = is_load ? 4'd5 : 4'd7;
          end
        end
        LSU_WAIT: begin
          if (lsu_rvalid_i) begin
            rf_we_o       = 1'b1;
            pc_we_o       = 1'b1;
            instr_ready_o = 1'b1;
            state_nxt     = DISPATCH;
          end else if (tmo) begin
            state_nxt = TRAP;
            cause_nxt = 4'd5;
          end
        end
        TRAP: begin
          trap_o        = 1'b1;
          trap_cause_o  = cause;
          pc_we_o       = 1'b1;
          pc_sel_o      = SEL_TRAP;
          instr_ready_o = 1'b1;
          state_nxt     = DISPATCH;
        end
        default: state_nxt = DISPATCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= DISPATCH;
      cause   <= 4'd0;
      is_load <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      cause   <= cause_nxt;
      is_load <= is_load_nxt;
      // Counts only while staying inside the LSU states; entry and exit both clear.
      cnt     <= (in_lsu && (state_nxt == LSU_REQ || state_nxt == LSU_WAIT)) ? cnt_inc : '0;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboarded random bench for core_sequencer: the driver pushes the modelled
// outcome of each instruction, the monitor tallies DUT activity and compares at retire.
module tb_core_sequencer;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       ill = 1'b0, ecl = 1'b0, ebr = 1'b0, mret = 1'b0, jmp = 1'b0, br = 1'b0;
  logic       ld = 1'b0, st = 1'b0, rf_we_in = 1'b0, taken = 1'b0;
  logic       cyc_cnt, rf_we_out, lsu_req, lsu_gnt = 1'b0, lsu_rvalid = 1'b0;
  logic       pc_we, trap;
  logic [1:0] pc_sel;
  logic [3:0] trap_cause;

  core_sequencer #(.LSU_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .illegal_inst_i(ill), .ecall_inst_i(ecl), .ebreak_inst_i(ebr), .mret_inst_i(mret),
    .jump_inst_i(jmp), .branch_inst_i(br), .lsu_r_en_i(ld), .lsu_w_en_i(st),
    .rf_we_i(rf_we_in), .branch_taken_i(taken), .cycle_counter_o(cyc_cnt),
    .rf_we_o(rf_we_out), .lsu_req_o(lsu_req), .lsu_gnt_i(lsu_gnt),
    .lsu_rvalid_i(lsu_rvalid), .pc_we_o(pc_we), .pc_sel_o(pc_sel),
    .trap_o(trap), .trap_cause_o(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles; int rf; int req; int cc;
    int sel; int trp; int cause;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // Outcome of one instruction from the flag priority, the LSU latencies and the
  // timeout window: dispatch cycle plus at most T-1 cycles waiting on the LSU.
  function automatic exp_t model(input logic f_ill, f_ebr, f_ecl, f_mret, f_jmp, f_br,
                                 f_ld, f_st, f_rf, f_tk, input int g, input int r);
    exp_t e;
    e = '{cycles: 1, rf: 0, req: 0, cc: 0, sel: 0, trp: 0, cause: 0};
    if (f_ill || f_ebr || f_ecl) begin
      e.cycles = 2; e.sel = 2; e.trp = 1;
      e.cause = f_ill ? 2 : (f_ebr ? 3 : 11);
    end else if (f_mret) begin
      e.sel = 3;
    end else if (f_jmp) begin
      e.cycles = 2; e.sel = 1; e.cc = 1; e.rf = int'(f_rf);
    end else if (f_br) begin
      if (f_tk) begin e.cycles = 2; e.sel = 1; e.cc = 1; end
    end else if (f_ld) begin
      if (g <= T - 2 && g + r + 1 <= T - 1) begin
        e.cycles = g + r + 2; e.req = g + 1; e.rf = 1;
      end else begin
        e.cycles = T + 1; e.req = (g <= T - 2) ? g + 1 : T;
        e.sel = 2; e.trp = 1; e.cause = 5;
      end
    end else if (f_st) begin
      if (g <= T - 1) begin
        e.cycles = g + 1; e.req = g + 1;
      end else begin
        e.cycles = T + 1; e.req = T; e.sel = 2; e.trp = 1; e.cause = 7;
      end
    end else begin
      e.rf = int'(f_rf);
    end
    return e;
  endfunction

  // Monitor
  int   m_cyc = 0, m_rf = 0, m_req = 0, m_cc = 0, m_pcwe = 0;
  exp_t me;
  always @(negedge clk) begin
    if (mon_en && rst_n && instr_valid) begin
      m_cyc++;
      m_rf   += int'(rf_we_out);
      m_req  += int'(lsu_req);
      m_cc   += int'(cyc_cnt);
      m_pcwe += int'(pc_we);
      if (instr_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          me = sbq.pop_front();
          chk("cycles", m_cyc, me.cycles);
          chk("rf_we_cnt", m_rf, me.rf);
          chk("lsu_req_cnt", m_req, me.req);
          chk("exec2_cnt", m_cc, me.cc);
          chk("pc_we_cnt", m_pcwe, 1);
          chk("pc_sel", int'(pc_sel), me.sel);
          chk("trap", int'(trap), me.trp);
          chk("trap_cause", int'(trap_cause), me.cause);
        end
        m_cyc = 0; m_rf = 0; m_req = 0; m_cc = 0; m_pcwe = 0;
      end
    end
  end

  task automatic clear_inputs();
    instr_valid = 0; ill = 0; ecl = 0; ebr = 0; mret = 0; jmp = 0; br = 0;
    ld = 0; st = 0; rf_we_in = 0; taken = 0; lsu_gnt = 0; lsu_rvalid = 0;
  endtask

  task automatic issue(input logic f_ill, f_ebr, f_ecl, f_mret, f_jmp, f_br,
                       f_ld, f_st, f_rf, f_tk, input int g, input int r);
    int  cyc;
    bit  done;
    sbq.push_back(model(f_ill, f_ebr, f_ecl, f_mret, f_jmp, f_br, f_ld, f_st, f_rf, f_tk, g, r));
    @(posedge clk); #1;
    ill = f_ill; ebr = f_ebr; ecl = f_ecl; mret = f_mret; jmp = f_jmp; br = f_br;
    ld = f_ld; st = f_st; rf_we_in = f_rf; taken = f_tk; instr_valid = 1;
    cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      lsu_gnt    = (f_ld || f_st) && (cyc == g);
      lsu_rvalid = f_ld && (cyc == g + 1 + r);
      @(negedge clk);
      if (instr_ready) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("retire_timeout", cyc, -1);
    clear_inputs();
  endtask

  initial begin
    logic [9:0] f;
    int k, g, r;
    // Outputs held low under reset even with an instruction presented
    instr_valid = 1; rf_we_in = 1; ld = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(instr_ready), 0);
    chk("rst_rf_we", int'(rf_we_out), 0);
    chk("rst_lsu_req", int'(lsu_req), 0);
    chk("rst_pc_we", int'(pc_we), 0);
    clear_inputs();
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("idle_pc_we", int'(pc_we), 0);
    chk("idle_ready", int'(instr_ready), 0);
    mon_en = 1;

    // Directed cases: ADD, JAL, BEQ taken/not, LW, SW timeout, illegal+jump, mret
    issue(0,0,0,0,0,0,0,0,1,0, 0,0);
    issue(0,0,0,0,1,0,0,0,1,0, 0,0);
    issue(0,0,0,0,0,1,0,0,0,1, 0,0);
    issue(0,0,0,0,0,1,0,0,0,0, 0,0);
    issue(0,0,0,0,0,0,1,0,1,0, 3,1);
    issue(0,0,0,0,0,0,0,1,0,0, 99,0);
    issue(1,0,0,0,1,0,0,0,1,0, 0,0);
    issue(0,0,0,1,0,0,0,0,0,0, 0,0);
    issue(0,0,0,0,0,0,0,1,0,0, T-1,0);
    issue(0,0,0,0,0,0,1,0,1,0, 0,T-2);
    issue(0,0,0,0,0,0,1,0,1,0, 0,T-1);

    // Random: one primary flag plus sparse extra flags to exercise priority
    for (int n = 0; n < 150; n++) begin
      k = int'($urandom_range(0, 9));
      f = '0;
      for (int b = 0; b < 10; b++) if ($urandom_range(0, 9) == 0) f[b] = 1'b1;
      if (k < 8) f[k] = 1'b1;
      if (f[6]) g = ($urandom_range(0, 4) == 0) ? 99 : int'($urandom_range(0, T-2));
      else      g = int'($urandom_range(0, T+2));
      r = int'($urandom_range(0, T));
      issue(f[0], f[1], f[2], f[3], f[4], f[5], f[6], f[7], f[8], f[9], g, r);
    end

    // Reset while a load sits in LSU_WAIT
    mon_en = 0;
    @(posedge clk); #1;
    instr_valid = 1; ld = 1; rf_we_in = 1; lsu_gnt = 1;
    @(posedge clk); #1 lsu_gnt = 0;
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("midrst_ready", int'(instr_ready), 0);
    chk("midrst_lsu_req", int'(lsu_req), 0);
    chk("midrst_rf_we", int'(rf_we_out), 0);
    chk("midrst_trap", int'(trap), 0);
    @(posedge clk); #1 rst_n = 1; clear_inputs();
    @(negedge clk);
    chk("postrst_ready", int'(instr_ready), 0);
    chk("postrst_lsu_req", int'(lsu_req), 0);
    chk("postrst_pc_we", int'(pc_we), 0);
    mon_en = 1;
    // A store granted at once only retires if the sequencer is back in DISPATCH
    issue(0,0,0,0,0,0,0,1,0,0, 0,0);
    issue(0,0,0,0,0,0,0,0,1,0, 0,0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
